lcdi_coef_apply: RTL

Consumer side of the LCDI gradient-classification stage. Takes the 7-bit class index and the three aligned samples produced at `LCDI_STATE6` and looks up a per-class set of three signed interpolation coefficients. It forms the weighted sum, rounds and clamps it, and returns one interpolated pixel per accepted sample. It also owns loading of the 81-entry coefficient table.

---
 rtl/lcdi_coef_apply.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/lcdi_coef_apply.sv
// rtl/lcdi_coef_apply.sv - LCDI coefficient table and weighted-sum interpolation pipeline
//
// Purpose: holds an NUM_CLASS-entry table of three signed coefficients per
// gradient class, loaded word by word, and turns each accepted
// {index, data0..2} sample into one rounded, clamped interpolated pixel.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid, index       sample strobe and 7-bit class index
//   data0_in..data2_in    unsigned samples aligned with index
//   load_start            begin (or restart) a full table load
//   coef_wr_valid/_data   coefficient word {c2,c1,c0}, c0 in the LSBs
//   load_busy             high while loading
//   table_ready           high once all entries are written
//   data_out, data_valid  interpolated pixel and its strobe
//   index_err             pulse with data_valid for an out-of-range index
//   drop_err              sticky: a sample arrived while not ready
module lcdi_coef_apply #(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 8,
  parameter int NUM_CLASS  = 81
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [6:0]              index,
  input  logic [DATA_WIDTH-1:0]   data0_in,
  input  logic [DATA_WIDTH-1:0]   data1_in,
  input  logic [DATA_WIDTH-1:0]   data2_in,
  input  logic                    load_start,
  input  logic                    coef_wr_valid,
  input  logic [3*COEF_WIDTH-1:0] coef_wr_data,
  output logic                    load_busy,
  output logic                    table_ready,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_valid,
  output logic                    index_err,
  output logic                    drop_err
);

  localparam int PW   = COEF_WIDTH + DATA_WIDTH + 1;  // product width
  localparam int SW   = PW + 2;                       // sum width, room for three terms
  localparam int FRAC = 6;                            // coefficient fractional bits
  localparam logic signed [SW-1:0] HALF = SW'(1 << (FRAC - 1));
  localparam logic [6:0] LAST_IDX = 7'(NUM_CLASS - 1);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_LOAD,
    ST_READY
  } state_t;

  state_t state;
  logic [6:0] wr_cnt;

  logic [3*COEF_WIDTH-1:0] coef_mem [NUM_CLASS];

  // Pipeline registers: stage 0 captures the inputs, stage 1 reads the
  // table, stage 2 multiplies, stage 3 sums/rounds/clamps into data_out.
  logic                    v0, v1, v2;
  logic [6:0]              idx0;
  logic [DATA_WIDTH-1:0]   d0_0, d1_0, d2_0;
  logic [DATA_WIDTH-1:0]   d0_1, d1_1, d2_1;
  logic [DATA_WIDTH-1:0]   d1_2;
  logic                    oor1, oor2;
  logic [3*COEF_WIDTH-1:0] coef1;
  logic signed [PW-1:0]    p0_2, p1_2, p2_2;

  logic                    tab_we;
  logic signed [SW-1:0]    sum3;
  logic signed [SW-1:0]    rnd3;
  logic [DATA_WIDTH-1:0]   pix3;

  function automatic logic signed [PW-1:0] coef_mul(
    input logic [COEF_WIDTH-1:0] c,
    input logic [DATA_WIDTH-1:0] d
  );
    logic signed [PW-1:0] ce;
    logic signed [PW-1:0] de;
    ce = PW'($signed(c));
    de = PW'({1'b0, d});
    return ce * de;
  endfunction

  // A load_start in LOAD restarts addressing; a coincident word is dropped.
  assign tab_we = (state == ST_LOAD) && coef_wr_valid && !load_start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      wr_cnt      <= '0;
      load_busy   <= 1'b0;
      table_ready <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (load_start) begin
            state     <= ST_LOAD;
            wr_cnt    <= '0;
            load_busy <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (load_start) begin
            wr_cnt <= '0;
          end else if (coef_wr_valid) begin
            wr_cnt <= wr_cnt + 7'd1;
            if (wr_cnt == LAST_IDX) begin
              state       <= ST_READY;
              load_busy   <= 1'b0;
              table_ready <= 1'b1;
            end
          end
        end
        ST_READY: begin
          if (load_start) begin
            state       <= ST_LOAD;
            wr_cnt      <= '0;
            load_busy   <= 1'b1;
            table_ready <= 1'b0;
          end
        end
        default: begin
          state       <= ST_EMPTY;
          load_busy   <= 1'b0;
          table_ready <= 1'b0;
        end
      endcase
    end
  end

  // Table is deliberately not reset; the FSM gates its use instead.
  always_ff @(posedge clk) begin
    if (tab_we) begin
      coef_mem[wr_cnt] <= coef_wr_data;
    end
  end

  // Datapath registers without reset; only valids/outputs need it.
  always_ff @(posedge clk) begin
    idx0 <= index;
    d0_0 <= data0_in;
    d1_0 <= data1_in;
    d2_0 <= data2_in;

    // Non-blocking read: a same-cycle write to this entry is not seen yet.
    coef1 <= (idx0 <= LAST_IDX) ? coef_mem[idx0] : '0;
    oor1  <= (idx0 > LAST_IDX);
    d0_1  <= d0_0;
    d1_1  <= d1_0;
    d2_1  <= d2_0;

    p0_2 <= coef_mul(coef1[COEF_WIDTH-1:0], d0_1);
    p1_2 <= coef_mul(coef1[2*COEF_WIDTH-1:COEF_WIDTH], d1_1);
    p2_2 <= coef_mul(coef1[3*COEF_WIDTH-1:2*COEF_WIDTH], d2_1);
    oor2 <= oor1;
    d1_2 <= d1_1;
  end

  always_comb begin
    sum3 = SW'(p0_2) + SW'(p1_2) + SW'(p2_2);
    rnd3 = (sum3 + HALF) >>> FRAC;
    if (rnd3[SW-1]) begin
      pix3 = '0;
    end else if (|rnd3[SW-2:DATA_WIDTH]) begin
      pix3 = '1;
    end else begin
      pix3 = rnd3[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0         <= 1'b0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      data_valid <= 1'b0;
      index_err  <= 1'b0;
      data_out   <= '0;
      drop_err   <= 1'b0;
    end else begin
      v0         <= in_valid && (state == ST_READY);
      v1         <= v0;
      v2         <= v1;
      data_valid <= v2;
      index_err  <= v2 && oor2;
      if (v2) begin
        data_out <= oor2 ? d1_2 : pix3;
      end
      if (in_valid && (state != ST_READY)) begin
        drop_err <= 1'b1;
      end
    end
  end

endmodule
